// File: rtl/alu_issuer_pkg.sv
// Shared encodings for the ALU issuer: opcodes, instruction fields, FSM states.
// Also imported by the assembler-facing tests, so encodings must stay stable.
package alu_issuer_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_SHR  = 4'h1,
    OP_SHL  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_ORR  = 4'h6,
    OP_XOR  = 4'h7,
    OP_CMP  = 4'h8,
    OP_LDI  = 4'h9,
    OP_JEQ  = 4'hA,
    OP_JGT  = 4'hB,
    OP_JLT  = 4'hC,
    OP_JZ   = 4'hD,
    OP_JMP  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Field layout: [15:12] opcode, [11:10] dst, [9:8] src, [7:0] imm.
  typedef struct packed {
    opcode_e    opcode;
    logic [1:0] dst;
    logic [1:0] src;
    logic [7:0] imm;
  } instr_t;

  function automatic logic writes_result(opcode_e op);
    return (op >= OP_SHR) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/alu_issuer_regfile.sv
// R0-R3 storage: one synchronous write port, three combinational read ports
// (left operand, right operand, debug).
module alu_issuer_regfile
  import alu_issuer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [1:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        raddr_a_i,
  input  logic [1:0]        raddr_b_i,
  input  logic [1:0]        raddr_c_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  output logic [DATA_W-1:0] rdata_c_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];
  assign rdata_c_o = regs_q[raddr_c_i];

endmodule

// File: rtl/alu_issuer.sv
// Single-issue sequencer driving an external ALU: latch, execute one cycle, retire.
//   state   | meaning
//   ST_IDLE | ready for an instruction
//   ST_EXEC | latched instruction drives strobes/branch; writes back at cycle end
//   ST_HALT | HALT retired; frozen until RST
module alu_issuer
  import alu_issuer_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] INSTR,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  output logic [15:0] LEFT,
  output logic [15:0] RIGHT,
  output logic        SHR,
  output logic        SHL,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        ORR,
  output logic        XOR,
  output logic        CMP,
  input  logic [15:0] RESULT,
  input  logic        FLAG_ZERO,
  input  logic        FLAG_EQUAL,
  input  logic        FLAG_GREATER_THAN,
  input  logic        FLAG_LESS_THAN,
  output logic        BRANCH_TAKEN,
  output logic [7:0]  BRANCH_TARGET,
  output logic        HALTED,
  output logic [15:0] RETIRED,
  input  logic [1:0]  DBG_SEL,
  output logic [15:0] DBG_DATA
);

  state_e      state_q, state_d;
  instr_t      instr_q, instr_d;
  logic [15:0] retired_q, retired_d;

  logic        exec;
  logic        taken;
  logic        rf_we;
  logic [15:0] rf_wdata;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE: begin
        if (INSTR_VALID) begin
          instr_d = instr_t'(INSTR);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        retired_d = retired_q + 16'd1;
        state_d   = (instr_q.opcode == OP_HALT) ? ST_HALT : ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Everything visible is squashed while RST is high, even mid-EXEC.
  always_comb begin
    exec        = (state_q == ST_EXEC) && !RST;
    INSTR_READY = (state_q == ST_IDLE) && !RST;
    HALTED      = (state_q == ST_HALT);

    SHR = exec && (instr_q.opcode == OP_SHR);
    SHL = exec && (instr_q.opcode == OP_SHL);
    ADD = exec && (instr_q.opcode == OP_ADD);
    SUB = exec && (instr_q.opcode == OP_SUB);
    AND = exec && (instr_q.opcode == OP_AND);
    ORR = exec && (instr_q.opcode == OP_ORR);
    XOR = exec && (instr_q.opcode == OP_XOR);
    CMP = exec && (instr_q.opcode == OP_CMP);

    case (instr_q.opcode)
      OP_JEQ:  taken = FLAG_EQUAL;
      OP_JGT:  taken = FLAG_GREATER_THAN;
      OP_JLT:  taken = FLAG_LESS_THAN;
      OP_JZ:   taken = FLAG_ZERO;
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
    BRANCH_TAKEN  = exec && taken;
    BRANCH_TARGET = (exec && taken) ? instr_q.imm : 8'h00;

    rf_we    = exec && (writes_result(instr_q.opcode) || (instr_q.opcode == OP_LDI));
    rf_wdata = (instr_q.opcode == OP_LDI) ? {8'h00, instr_q.imm} : RESULT;
  end

  assign RETIRED = retired_q;

  alu_issuer_regfile u_regfile (
    .clk_i     (CLK),
    .rst_i     (RST),
    .we_i      (rf_we),
    .waddr_i   (instr_q.dst),
    .wdata_i   (rf_wdata),
    .raddr_a_i (instr_q.dst),
    .raddr_b_i (instr_q.src),
    .raddr_c_i (DBG_SEL),
    .rdata_a_o (LEFT),
    .rdata_b_o (RIGHT),
    .rdata_c_o (DBG_DATA)
  );

endmodule

// File: tb/tb_alu_issuer.sv
// Bench for alu_issuer: plays the ALU, issues directed and random programs, and
// compares against an instruction-level model of the register/flag state.
`timescale 1ns/1ps
module tb_alu_issuer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] INSTR;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [15:0] LEFT, RIGHT;
  logic        SHR, SHL, ADD, SUB, AND, ORR, XOR, CMP;
  logic [15:0] RESULT;
  logic        FLAG_ZERO, FLAG_EQUAL, FLAG_GREATER_THAN, FLAG_LESS_THAN;
  logic        BRANCH_TAKEN;
  logic [7:0]  BRANCH_TARGET;
  logic        HALTED;
  logic [15:0] RETIRED;
  logic [1:0]  DBG_SEL;
  logic [15:0] DBG_DATA;
  logic [7:0]  strobes;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] m_r [4];
  logic [15:0] m_ret;
  logic        m_eq, m_gt, m_lt, m_z, m_halt;

  alu_issuer dut (
    .CLK(CLK), .RST(RST), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .LEFT(LEFT), .RIGHT(RIGHT),
    .SHR(SHR), .SHL(SHL), .ADD(ADD), .SUB(SUB), .AND(AND), .ORR(ORR),
    .XOR(XOR), .CMP(CMP), .RESULT(RESULT), .FLAG_ZERO(FLAG_ZERO),
    .FLAG_EQUAL(FLAG_EQUAL), .FLAG_GREATER_THAN(FLAG_GREATER_THAN),
    .FLAG_LESS_THAN(FLAG_LESS_THAN), .BRANCH_TAKEN(BRANCH_TAKEN),
    .BRANCH_TARGET(BRANCH_TARGET), .HALTED(HALTED), .RETIRED(RETIRED),
    .DBG_SEL(DBG_SEL), .DBG_DATA(DBG_DATA)
  );

  always #10 CLK = ~CLK;

  assign strobes = {SHR, SHL, ADD, SUB, AND, ORR, XOR, CMP};

  // External ALU: combinational result, flags registered on CMP.
  always_comb begin
    RESULT = 16'h0000;
    if (SHR) RESULT = LEFT >> 1;
    if (SHL) RESULT = LEFT << 1;
    if (ADD) RESULT = LEFT + RIGHT;
    if (SUB) RESULT = LEFT - RIGHT;
    if (AND) RESULT = LEFT & RIGHT;
    if (ORR) RESULT = LEFT | RIGHT;
    if (XOR) RESULT = LEFT ^ RIGHT;
  end

  always @(posedge CLK) begin
    if (RST) begin
      FLAG_EQUAL <= 1'b0; FLAG_GREATER_THAN <= 1'b0;
      FLAG_LESS_THAN <= 1'b0; FLAG_ZERO <= 1'b0;
    end else if (CMP) begin
      FLAG_EQUAL        <= (LEFT == RIGHT);
      FLAG_GREATER_THAN <= (LEFT > RIGHT);
      FLAG_LESS_THAN    <= (LEFT < RIGHT);
      FLAG_ZERO         <= (16'(LEFT - RIGHT) == 16'h0000);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [1:0] sel, output logic [15:0] v);
    DBG_SEL = sel;
    #1;
    v = DBG_DATA;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 16'h0000;
    m_ret = 16'h0000;
    {m_eq, m_gt, m_lt, m_z, m_halt} = 5'b0;
  endtask

  // Called just after an edge that ends an instruction (or reset).
  task automatic check_state();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), v);
      check($sformatf("reg_r%0d", i), v, m_r[i]);
    end
    check("retired", RETIRED, m_ret);
    check("halted", HALTED, m_halt);
    check("ready", INSTR_READY, !m_halt);
    check("strobe_idle", strobes, 8'h00);
    check("branch_idle", BRANCH_TAKEN, 1'b0);
    check("target_idle", BRANCH_TARGET, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    INSTR_VALID = 1'($urandom_range(0, 1));
    INSTR = 16'($urandom);
    @(posedge CLK); #1;
    check("rst_ready", INSTR_READY, 1'b0);
    check("rst_strobe", strobes, 8'h00);
    check("rst_branch", BRANCH_TAKEN, 1'b0);
    check("rst_target", BRANCH_TARGET, 8'h00);
    @(negedge CLK);
    RST = 1'b0;
    INSTR_VALID = 1'b0;
    model_reset();
    @(posedge CLK); #1;
    check_state();
  endtask

  task automatic issue(input logic [15:0] w);
    int          waited;
    int          op;
    logic [1:0]  d, s;
    logic [7:0]  imm;
    logic [7:0]  exp_strobe;
    logic        exp_taken;
    logic [15:0] l, r;
    waited = 0;
    @(negedge CLK);
    while (!INSTR_READY && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    if (!INSTR_READY) begin
      check("ready_timeout", 1'b0, 1'b1);
      return;
    end
    INSTR = w;
    INSTR_VALID = 1'b1;
    @(posedge CLK); #1;
    INSTR_VALID = 1'b0;
    INSTR = 16'($urandom);
    op  = int'(w[15:12]);
    d   = w[11:10];
    s   = w[9:8];
    imm = w[7:0];
    exp_strobe = (op >= 1 && op <= 8) ? 8'(1 << (8 - op)) : 8'h00;
    case (op)
      10: exp_taken = m_eq;
      11: exp_taken = m_gt;
      12: exp_taken = m_lt;
      13: exp_taken = m_z;
      14: exp_taken = 1'b1;
      default: exp_taken = 1'b0;
    endcase
    check("exec_strobe", strobes, exp_strobe);
    check("exec_branch", BRANCH_TAKEN, exp_taken);
    check("exec_target", BRANCH_TARGET, exp_taken ? imm : 8'h00);
    check("exec_ready", INSTR_READY, 1'b0);
    check("exec_left", LEFT, m_r[d]);
    check("exec_right", RIGHT, m_r[s]);
    l = m_r[d];
    r = m_r[s];
    case (op)
      1: m_r[d] = l >> 1;
      2: m_r[d] = l << 1;
      3: m_r[d] = l + r;
      4: m_r[d] = l - r;
      5: m_r[d] = l & r;
      6: m_r[d] = l | r;
      7: m_r[d] = l ^ r;
      8: begin
        m_eq = (l == r); m_gt = (l > r); m_lt = (l < r);
        m_z  = (16'(l - r) == 16'h0000);
      end
      9: m_r[d] = {8'h00, imm};
      15: m_halt = 1'b1;
      default: ;
    endcase
    m_ret = m_ret + 16'd1;
    @(posedge CLK); #1;
    check_state();
  endtask

  function automatic logic [15:0] enc(input int op, input int d, input int s, input int imm);
    return {4'(op), 2'(d), 2'(s), 8'(imm)};
  endfunction

  initial begin
    logic [15:0] v;
    int          acc;
    RST = 1'b0; INSTR = 16'h0; INSTR_VALID = 1'b0; DBG_SEL = 2'd0;
    model_reset();
    do_reset();

    // LDI/LDI/SUB
    issue(enc(9, 1, 0, 8'h05));
    issue(enc(9, 2, 0, 8'h03));
    issue(enc(4, 1, 2, 0));
    rd(2'd1, v); check("sub_r1", v, 16'h0002);
    check("sub_retired", RETIRED, 16'd3);

    // Borrow wraps, then SHL with dst==src
    issue(enc(9, 0, 0, 8'h00));
    issue(enc(9, 3, 0, 8'h01));
    issue(enc(4, 0, 3, 0));
    rd(2'd0, v); check("sub_wrap_r0", v, 16'hFFFF);
    issue(enc(2, 0, 0, 0));
    rd(2'd0, v); check("shl_r0", v, 16'hFFFE);

    // CMP equal then JEQ taken, JLT not
    issue(enc(9, 1, 0, 8'h07));
    issue(enc(9, 2, 0, 8'h07));
    issue(enc(8, 1, 2, 0));
    issue(enc(10, 0, 0, 8'h40));
    issue(enc(12, 0, 0, 8'h41));

    // Flags clear after reset: JZ not taken, JMP taken
    do_reset();
    issue(enc(13, 0, 0, 8'h10));
    issue(enc(14, 0, 0, 8'h22));

    // Back-to-back ADD stream with INSTR_VALID held high
    issue(enc(9, 1, 0, 8'h11));
    issue(enc(9, 2, 0, 8'h03));
    acc = 0;
    @(negedge CLK);
    INSTR = enc(3, 1, 2, 0);
    INSTR_VALID = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("stream_ready", INSTR_READY, (i % 2) == 0);
      check("stream_strobe", strobes, (i % 2) ? 8'h20 : 8'h00);
      if (INSTR_READY) begin
        acc++;
        m_r[1] = m_r[1] + m_r[2];
        m_ret  = m_ret + 16'd1;
      end
      @(negedge CLK);
    end
    INSTR_VALID = 1'b0;
    check("stream_accepts", acc, 6);
    @(posedge CLK); #1;
    check_state();

    // Random programs (no HALT)
    for (int n = 0; n < 300; n++) begin
      v = 16'($urandom);
      v[15:12] = 4'($urandom_range(0, 14));
      issue(v);
    end

    // Reset in the middle of EXEC aborts the ADD
    do_reset();
    issue(enc(9, 2, 0, 8'h05));
    @(negedge CLK);
    INSTR = enc(3, 1, 2, 0);
    INSTR_VALID = 1'b1;
    @(posedge CLK); #1;
    INSTR_VALID = 1'b0;
    RST = 1'b1;
    #1;
    check("abort_strobe", strobes, 8'h00);
    @(posedge CLK); #1;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    @(posedge CLK); #1;
    rd(2'd1, v); check("abort_r1", v, 16'h0000);
    check("abort_retired", RETIRED, 16'd0);
    check_state();

    // HALT freezes the issuer until reset
    issue(enc(9, 3, 0, 8'h5A));
    issue(enc(15, 0, 0, 0));
    @(negedge CLK);
    INSTR = enc(9, 0, 0, 8'hAA);
    INSTR_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("halt_ready", INSTR_READY, 1'b0);
      check("halt_halted", HALTED, 1'b1);
      check("halt_strobe", strobes, 8'h00);
      check("halt_retired", RETIRED, m_ret);
    end
    INSTR_VALID = 1'b0;
    check_state();
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issuer.md
ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 Clocking: one clock; reset is synchronous and active-high; ports CLK and RST.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 INSTR  input  16  instruction word: [15:12] opcode, [11:10] dst, [9:8] src, [7:0] imm.
REQ-005 INSTR_VALID  input  1  INSTR valid this cycle.
REQ-006 INSTR_READY  output  1  issuer accepts INSTR this cycle.
REQ-007 LEFT  output  16  ALU left operand, R[dst].
REQ-008 RIGHT  output  16  ALU right operand, R[src].
REQ-009 SHR, SHL, ADD, SUB, AND, ORR, XOR, CMP  output  1 each  one-hot ALU operation strobes.
REQ-010 RESULT  input  16  combinational ALU result.
REQ-011 FLAG_ZERO, FLAG_EQUAL, FLAG_GREATER_THAN, FLAG_LESS_THAN  input  1 each  registered ALU compare flags.
REQ-012 BRANCH_TAKEN  output  1  one-cycle pulse: branch resolved taken.
REQ-013 BRANCH_TARGET  output  8  imm of the taken branch; valid with BRANCH_TAKEN, 0 otherwise.
REQ-014 HALTED  output  1  HALT executed; held until reset.
REQ-015 RETIRED  output  16  count of completed instructions.
REQ-016 DBG_SEL  input  2  register select for debug read.
REQ-017 DBG_DATA  output  16  combinational R[DBG_SEL].

Function
REQ-018 Four 16-bit registers R0-R3 internal to the block.
REQ-019 Opcodes: 0 NOP, 1 SHR, 2 SHL, 3 ADD, 4 SUB, 5 AND, 6 ORR, 7 XOR, 8 CMP, 9 LDI, A JEQ, B JGT, C JLT, D JZ, E JMP, F HALT.
REQ-020 States: IDLE, EXEC, HALT. INSTR_READY=1 only in IDLE and not in RST.
REQ-021 IDLE: INSTR_VALID & INSTR_READY latches INSTR, -> EXEC; INSTR_VALID ignored in any other state.
REQ-022 EXEC lasts exactly one cycle; the strobe for opcodes 1-8 is high only in EXEC; all strobes 0 elsewhere; never more than one strobe high.
REQ-023 Opcodes 1-7: RESULT written to R[dst] at the EXEC-ending edge; arithmetic modulo 2^16 (ADD carry, SUB borrow discarded).
REQ-024 CMP: no register write; ALU updates flags at the EXEC-ending edge.
REQ-025 LDI: R[dst] <= {8'h00, imm}; no strobe.
REQ-026 JEQ/JGT/JLT/JZ: taken if FLAG_EQUAL/FLAG_GREATER_THAN/FLAG_LESS_THAN/FLAG_ZERO is 1 during EXEC; JMP always taken; taken -> BRANCH_TAKEN=1, BRANCH_TARGET=imm during EXEC.
REQ-027 Latency: accepted at edge N; strobe/branch during cycle N..N+1; R[dst] visible, INSTR_READY high again from edge N+1; max throughput one instruction per 2 cycles.
REQ-028 dst==src permitted; LEFT and RIGHT both carry the pre-write value.
REQ-029 HALT: EXEC -> HALT; HALTED=1, INSTR_READY=0 until RST.
REQ-030 RETIRED increments by 1 at every EXEC-ending edge (all opcodes incl. NOP, HALT); wraps FFFF -> 0000.
REQ-031 LEFT/RIGHT reflect the latched instruction fields at all times (don't-care outside EXEC but deterministic).

Reset
REQ-032 RST high at an edge: state IDLE, R0-R3=0, latched INSTR=0, RETIRED=0, HALTED=0; RST has priority over all events.
REQ-033 While RST is high: INSTR_READY=0, all strobes 0, BRANCH_TAKEN=0, BRANCH_TARGET=0.
REQ-034 RST during EXEC aborts: no register write, no RETIRED increment.

Structure
REQ-035 Opcode encodings, instruction field positions and state encodings SHALL live in a shared package also used by the assembler-facing tests.
REQ-036 One sub-module, alu_issuer_regfile (4x16, one write port, three combinational read ports), SHALL hold R0-R3.

Verification
REQ-037 LDI R1,0x05; LDI R2,0x03; SUB R1,R2 -> SUB high one cycle, R1=0x0002, RETIRED=3.
REQ-038 LDI R0,0x00; LDI R3,0x01; SUB R0,R3 -> R0=0xFFFF; SHL R0,R0 -> R0=0xFFFE.
REQ-039 LDI R1,0x07; LDI R2,0x07; CMP R1,R2; JEQ imm=0x40 -> BRANCH_TAKEN one cycle, BRANCH_TARGET=0x40; JLT -> no pulse.
REQ-040 After reset (flags 0) JZ imm=0x10 -> not taken; JMP imm=0x22 -> taken, target 0x22.
REQ-041 INSTR_VALID held high continuously with ADD stream -> exactly one accept per 2 cycles, strobes one-hot.
REQ-042 RST asserted during EXEC of ADD R1,R2 -> R1 stays 0, RETIRED=0; HALT then INSTR_VALID -> INSTR_READY=0, HALTED=1 until RST.
